// File: rtl/plank_frame_parser.sv
// Plank frame parser: assembles 21-byte UART command frames
// (header, power mask, 8 attenuation words, 8 phase words, spare, XOR checksum, footer)
// into shadow registers and commits all 104 output bits at once when a frame is valid.
module plank_frame_parser #(
   parameter int unsigned TIMEOUT_CLKS = 17360,
   parameter logic [7:0]  HDR          = 8'hAA,
   parameter logic [7:0]  FTR          = 8'h55
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx_dv,
   input  logic [7:0]  i_rx_byte,
   output logic [7:0]  o_ch_power,
   output logic [47:0] o_attn_bus,
   output logic [47:0] o_phase_bus,
   output logic        o_frame_done,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic        o_busy
);

   // The timer only has to hold values up to TIMEOUT_CLKS-1; the terminal
   // increment is detected combinationally and never stored.
   localparam int unsigned TW         = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [4:0]  LAST_IDX   = 5'd17;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      FOOTER  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] timer;
   logic [4:0]    idx;
   logic [7:0]    xor_sum;
   logic [7:0]    power_sh;
   logic [47:0]   attn_sh;
   logic [47:0]   phase_sh;

   logic          timeout_hit;
   logic          checksum_ok;
   logic          start_frame;
   logic          store_byte;
   logic          commit;
   logic          reject;
   logic [1:0]    err_code_next;

   // A strobe in the same cycle as the terminal count always wins over the timeout.
   assign timeout_hit = (state != IDLE) && !i_rx_dv && (timer == TIMER_LAST);
   assign checksum_ok = (i_rx_byte == xor_sum);
   assign o_busy      = (state != IDLE);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: header opens a frame, 18 payload bytes, checksum, footer.
   always_comb begin
      state_next = state;
      if (timeout_hit) begin
         state_next = IDLE;
      end else if (i_rx_dv) begin
         case (state)
            IDLE:    if (i_rx_byte == HDR) state_next = PAYLOAD;
            PAYLOAD: if (idx == LAST_IDX) state_next = CHECK;
            CHECK:   state_next = checksum_ok ? FOOTER : IDLE;
            FOOTER:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Control decode: which datapath action this cycle's strobe (or timeout) causes.
   always_comb begin
      start_frame   = 1'b0;
      store_byte    = 1'b0;
      commit        = 1'b0;
      reject        = 1'b0;
      err_code_next = 2'b00;
      if (timeout_hit) begin
         reject        = 1'b1;
         err_code_next = 2'b11;
      end else if (i_rx_dv) begin
         case (state)
            IDLE:    start_frame = (i_rx_byte == HDR);
            PAYLOAD: store_byte  = 1'b1;
            CHECK: begin
               if (!checksum_ok) begin
                  reject        = 1'b1;
                  err_code_next = 2'b01;
               end
            end
            FOOTER: begin
               if (i_rx_byte == FTR) begin
                  commit = 1'b1;
               end else begin
                  reject        = 1'b1;
                  err_code_next = 2'b10;
               end
            end
            default: begin
               start_frame = 1'b0;
            end
         endcase
      end
   end

   // Inter-byte timer: runs only inside a frame and restarts on every accepted byte.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         timer <= '0;
      end else if (i_rx_dv || (state_next == IDLE)) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // Shadow capture: payload bytes land by index, checksum covers all 8 bits of each.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx      <= '0;
         xor_sum  <= '0;
         power_sh <= '0;
         attn_sh  <= '0;
         phase_sh <= '0;
      end else if (timeout_hit) begin
         idx      <= '0;
         xor_sum  <= '0;
         power_sh <= '0;
         attn_sh  <= '0;
         phase_sh <= '0;
      end else if (start_frame) begin
         idx     <= '0;
         xor_sum <= '0;
      end else if (store_byte) begin
         idx     <= idx + 5'd1;
         xor_sum <= xor_sum ^ i_rx_byte;
         if (idx == 5'd0) begin
            power_sh <= i_rx_byte;
         end
         for (int c = 0; c < 8; c++) begin
            if (idx == 5'(c + 1)) attn_sh[6*c +: 6]  <= i_rx_byte[5:0];
            if (idx == 5'(c + 9)) phase_sh[6*c +: 6] <= i_rx_byte[5:0];
         end
      end
   end

   // Output registers: a commit moves the whole shadow set in one edge; pulses last one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ch_power   <= '0;
         o_attn_bus   <= '0;
         o_phase_bus  <= '0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_err_code   <= 2'b00;
      end else begin
         o_frame_done <= commit;
         o_frame_err  <= reject;
         if (commit) begin
            o_ch_power  <= power_sh;
            o_attn_bus  <= attn_sh;
            o_phase_bus <= phase_sh;
            o_err_code  <= 2'b00;
         end else if (reject) begin
            o_err_code  <= err_code_next;
         end
      end
   end

endmodule

// File: tb/tb_plank_frame_parser.sv
// Testbench for plank_frame_parser: frame-level reference model with an event
// queue, checked every cycle, plus literal expectations for the nominal frames.
module tb_plank_frame_parser;

   localparam int         T   = 64;
   localparam logic [7:0] HDR = 8'hAA;
   localparam logic [7:0] FTR = 8'h55;

   localparam int EV_DONE  = 0;
   localparam int EV_ERR   = 1;
   localparam int EV_RESET = 2;
   localparam int EV_BUSY  = 3;

   typedef logic [7:0] frame_t [21];
   typedef struct {
      int          cyc;
      int          kind;
      logic [7:0]  pw;
      logic [47:0] at;
      logic [47:0] ph;
      logic [1:0]  code;
   } evt_t;

   logic        i_clk;
   logic        i_rst;
   logic        i_rx_dv;
   logic [7:0]  i_rx_byte;
   logic [7:0]  o_ch_power;
   logic [47:0] o_attn_bus;
   logic [47:0] o_phase_bus;
   logic        o_frame_done;
   logic        o_frame_err;
   logic [1:0]  o_err_code;
   logic        o_busy;

   plank_frame_parser #(
      .TIMEOUT_CLKS(T),
      .HDR(HDR),
      .FTR(FTR)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_rx_dv(i_rx_dv),
      .i_rx_byte(i_rx_byte),
      .o_ch_power(o_ch_power),
      .o_attn_bus(o_attn_bus),
      .o_phase_bus(o_phase_bus),
      .o_frame_done(o_frame_done),
      .o_frame_err(o_frame_err),
      .o_err_code(o_err_code),
      .o_busy(o_busy)
   );

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          last_cyc = 0;
   bit          chk_en = 1'b0;
   evt_t        evq[$];
   evt_t        ev;
   logic [7:0]  m_power = '0;
   logic [47:0] m_attn = '0;
   logic [47:0] m_phase = '0;
   logic [1:0]  m_code = '0;
   bit          m_done = 1'b0;
   bit          m_err = 1'b0;
   bit          m_busy = 1'b0;

   // Free-running clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Cycle counter used to time-stamp expected events.
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   task automatic pushEvt(input int c, input int kind, input logic [7:0] pw,
                          input logic [47:0] at, input logic [47:0] ph, input logic [1:0] code);
      evt_t e;
      e.cyc  = c;
      e.kind = kind;
      e.pw   = pw;
      e.at   = at;
      e.ph   = ph;
      e.code = code;
      evq.push_back(e);
   endtask

   function automatic logic [7:0] frameXor(input frame_t f);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 1; i <= 18; i++) x = x ^ f[i];
      return x;
   endfunction

   function automatic logic [47:0] attnOf(input frame_t f);
      logic [47:0] r;
      r = '0;
      for (int c = 0; c < 8; c++) r[6*c +: 6] = f[2+c][5:0];
      return r;
   endfunction

   function automatic logic [47:0] phaseOf(input frame_t f);
      logic [47:0] r;
      r = '0;
      for (int c = 0; c < 8; c++) r[6*c +: 6] = f[10+c][5:0];
      return r;
   endfunction

   function automatic frame_t makeFrame();
      frame_t f;
      f[0] = HDR;
      for (int i = 1; i <= 18; i++) f[i] = ($urandom_range(7, 0) == 0) ? HDR : 8'($urandom);
      f[19] = frameXor(f);
      f[20] = FTR;
      return f;
   endfunction

   function automatic frame_t nominalFrame();
      frame_t f;
      f[0] = HDR;
      f[1] = 8'hF2;
      for (int i = 2; i <= 18; i++) f[i] = 8'h37;
      f[19] = 8'hC5;
      f[20] = FTR;
      return f;
   endfunction

   // Per-cycle comparison of every output against the frame-level model.
   always @(negedge i_clk) begin
      if (chk_en) begin
         m_done = 1'b0;
         m_err  = 1'b0;
         while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            ev = evq.pop_front();
            case (ev.kind)
               EV_DONE: begin
                  m_done  = 1'b1;
                  m_power = ev.pw;
                  m_attn  = ev.at;
                  m_phase = ev.ph;
                  m_code  = 2'b00;
                  m_busy  = 1'b0;
               end
               EV_ERR: begin
                  m_err  = 1'b1;
                  m_code = ev.code;
                  m_busy = 1'b0;
               end
               EV_RESET: begin
                  m_power = '0;
                  m_attn  = '0;
                  m_phase = '0;
                  m_code  = 2'b00;
                  m_busy  = 1'b0;
               end
               default: m_busy = 1'b1;
            endcase
         end
         checkOutput("frame_done", 48'(o_frame_done), 48'(m_done));
         checkOutput("frame_err", 48'(o_frame_err), 48'(m_err));
         checkOutput("err_code", 48'(o_err_code), 48'(m_code));
         checkOutput("busy", 48'(o_busy), 48'(m_busy));
         checkOutput("ch_power", 48'(o_ch_power), 48'(m_power));
         checkOutput("attn_bus", o_attn_bus, m_attn);
         checkOutput("phase_bus", o_phase_bus, m_phase);
      end
   end

   // Drives one byte strobe; last_cyc is the cycle whose edge sampled it.
   task automatic applyStimulus(input logic [7:0] b);
      i_rx_dv   = 1'b1;
      i_rx_byte = b;
      @(posedge i_clk);
      #1;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'($urandom);
      last_cyc  = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // Sends the first n_bytes of f with random gaps and queues the expected result.
   task automatic runFrame(input frame_t f, input int n_bytes, input int max_gap, input bit expect_timeout);
      for (int i = 0; i < n_bytes; i++) begin
         applyStimulus(f[i]);
         if (i == 0) pushEvt(last_cyc, EV_BUSY, '0, '0, '0, 2'b00);
         if (i == 19 && frameXor(f) != f[19]) begin
            pushEvt(last_cyc, EV_ERR, '0, '0, '0, 2'b01);
            return;
         end
         if (i == 20) begin
            if (f[20] == FTR) pushEvt(last_cyc, EV_DONE, f[1], attnOf(f), phaseOf(f), 2'b00);
            else pushEvt(last_cyc, EV_ERR, '0, '0, '0, 2'b10);
            return;
         end
         if (i < n_bytes - 1) idle($urandom_range(max_gap, 0));
      end
      if (expect_timeout) begin
         pushEvt(last_cyc + T, EV_ERR, '0, '0, '0, 2'b11);
         idle(T + 3);
      end
   endtask

   task automatic sendGarbage(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         while (b == HDR) b = 8'($urandom);
         applyStimulus(b);
         idle($urandom_range(2, 0));
      end
   endtask

   // Watchdog so the run always ends on its own.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main scenario sequence.
   initial begin
      frame_t nom;
      frame_t f;
      frame_t g;
      int     r;
      i_rst     = 1'b1;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h00;
      @(posedge i_clk);
      #1;
      chk_en = 1'b1;
      idle(2);
      checkOutput("reset_power", 48'(o_ch_power), 48'h0);
      checkOutput("reset_attn", o_attn_bus, 48'h0);
      checkOutput("reset_code", 48'(o_err_code), 48'h0);
      checkOutput("reset_busy", 48'(o_busy), 48'h0);
      i_rst = 1'b0;
      idle(2);

      nom = nominalFrame();
      runFrame(nom, 21, 0, 1'b0);
      checkOutput("nom_done", 48'(o_frame_done), 48'h1);
      checkOutput("nom_power", 48'(o_ch_power), 48'hF2);
      checkOutput("nom_attn", o_attn_bus, {8{6'h37}});
      checkOutput("nom_phase", o_phase_bus, {8{6'h37}});
      checkOutput("nom_code", 48'(o_err_code), 48'h0);
      idle(1);
      checkOutput("nom_done_end", 48'(o_frame_done), 48'h0);
      idle(2);

      f = nom;
      f[19] = 8'h00;
      runFrame(f, 21, 2, 1'b0);
      checkOutput("chk_err", 48'(o_frame_err), 48'h1);
      checkOutput("chk_code", 48'(o_err_code), 48'h1);
      checkOutput("chk_power_kept", 48'(o_ch_power), 48'hF2);
      idle(3);

      f = nom;
      f[20] = 8'h54;
      runFrame(f, 21, 2, 1'b0);
      checkOutput("ftr_err", 48'(o_frame_err), 48'h1);
      checkOutput("ftr_code", 48'(o_err_code), 48'h2);
      checkOutput("ftr_attn_kept", o_attn_bus, {8{6'h37}});
      idle(3);

      f = makeFrame();
      runFrame(f, 11, 3, 1'b1);
      checkOutput("tmo_code", 48'(o_err_code), 48'h3);
      checkOutput("tmo_busy", 48'(o_busy), 48'h0);
      f = makeFrame();
      runFrame(f, 21, 3, 1'b0);
      checkOutput("tmo_next_done", 48'(o_frame_done), 48'h1);
      checkOutput("tmo_next_power", 48'(o_ch_power), 48'(f[1]));
      idle(2);

      applyStimulus(8'h00);
      idle(1);
      applyStimulus(8'hFF);
      applyStimulus(8'h13);
      idle(2);
      runFrame(nom, 21, 1, 1'b0);
      checkOutput("garbage_done", 48'(o_frame_done), 48'h1);
      checkOutput("garbage_phase", o_phase_bus, {8{6'h37}});

      f = makeFrame();
      runFrame(f, 21, 0, 1'b0);
      g = makeFrame();
      runFrame(g, 21, 0, 1'b0);
      checkOutput("b2b_done", 48'(o_frame_done), 48'h1);
      checkOutput("b2b_power", 48'(o_ch_power), 48'(g[1]));
      idle(2);

      runFrame(nom, 13, 2, 1'b0);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      pushEvt(cyc, EV_RESET, '0, '0, '0, 2'b00);
      i_rst = 1'b0;
      checkOutput("midrst_power", 48'(o_ch_power), 48'h0);
      checkOutput("midrst_attn", o_attn_bus, 48'h0);
      checkOutput("midrst_busy", 48'(o_busy), 48'h0);
      for (int i = 13; i <= 20; i++) applyStimulus(nom[i]);
      idle(2);
      checkOutput("midrst_no_commit", 48'(o_ch_power), 48'h0);
      runFrame(nom, 21, 2, 1'b0);
      checkOutput("midrst_next_done", 48'(o_frame_done), 48'h1);
      idle(2);

      for (int k = 0; k < 40; k++) begin
         sendGarbage($urandom_range(3, 0));
         idle($urandom_range(3, 0));
         f = makeFrame();
         r = $urandom_range(99, 0);
         if (r < 65) begin
            runFrame(f, 21, 4, 1'b0);
         end else if (r < 78) begin
            f[19] = f[19] ^ 8'($urandom_range(255, 1));
            runFrame(f, 21, 4, 1'b0);
         end else if (r < 90) begin
            f[20] = 8'($urandom);
            while (f[20] == FTR) f[20] = 8'($urandom);
            runFrame(f, 21, 4, 1'b0);
         end else begin
            runFrame(f, $urandom_range(20, 1), 4, 1'b1);
         end
      end
      idle(4);

      $display("[TB] %0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/plank_frame_parser.md
PLANK_FRAME_PARSER -- requirements
Module: plank_frame_parser

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 17360, meaning the inter-byte timeout in i_clk cycles (2 byte times at 115200 baud, 100 MHz).
REQ-002 Parameter HDR, default 8'hAA, meaning the frame header byte.
REQ-003 Parameter FTR, default 8'h55, meaning the frame footer byte.
REQ-004 i_clk  input  1  system clock; the single clock domain.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_rx_dv  input  1  one-cycle strobe marking a received UART byte as valid.
REQ-007 i_rx_byte  input  8  received UART byte, valid only when i_rx_dv=1.
REQ-008 o_ch_power  output  8  committed channel power-enable mask; bit0 is ch1.
REQ-009 o_attn_bus  output  48  committed attenuation words; ch n occupies bits [6n-1:6n-6].
REQ-010 o_phase_bus  output  48  committed phase words; packed the same way as o_attn_bus.
REQ-011 o_frame_done  output  1  one-cycle pulse when a valid frame is committed.
REQ-012 o_frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-013 o_err_code  output  2  error cause, held until the next frame result: 01 checksum, 10 footer, 11 timeout, 00 none.
REQ-014 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Frame format is 21 bytes:
- byte0 = HDR.
- byte1 = power mask.
- bytes2-9 = attn ch1-8, bits[5:0].
- bytes10-17 = phase ch1-8, bits[5:0].
- byte18 = spare, ignored.
- byte19 = XOR of bytes1-18.
- byte20 = FTR.
REQ-016 FSM states SHALL be IDLE, PAYLOAD, CHECK and FOOTER.
REQ-017 IDLE: on i_rx_dv with byte==HDR, go to PAYLOAD, clear the byte index and running XOR, and clear the timeout counter; any other byte is discarded silently.
REQ-018 PAYLOAD: each i_rx_dv stores the byte in the shadow register for its index (1-18) and XORs it into the running checksum; after index 18, go to CHECK.
REQ-019 Bits[7:6] of attn/phase bytes are excluded from the outputs but included in the checksum.
REQ-020 CHECK: on i_rx_dv, compare the byte with the running XOR; if they match, go to FOOTER; otherwise pulse o_frame_err, set o_err_code=01 and go to IDLE.
REQ-021 FOOTER: on i_rx_dv with byte==FTR, copy the shadow registers to the outputs, pulse o_frame_done and set o_err_code=00, all on the cycle after the strobe; otherwise pulse o_frame_err, set o_err_code=10 and keep the outputs unchanged. Both cases return to IDLE.
REQ-022 Latency: outputs and the done/err pulse SHALL appear exactly 1 cycle after the strobe of the last byte.
REQ-023 The FSM is back in IDLE on that same cycle, so a HDR strobe arriving then starts a new frame.
REQ-024 Outputs SHALL never show a partially updated frame; all 104 output bits update in the same cycle.
REQ-025 Timeout counter:
- increments each cycle while not in IDLE;
- clears on every accepted i_rx_dv;
- on reaching TIMEOUT_CLKS: pulse o_frame_err, set o_err_code=11, go to IDLE and discard the shadow registers.
REQ-026 If a strobe and the timeout terminal count occur in the same cycle, the strobe wins and the counter clears.
REQ-027 A HDR-valued byte received mid-frame is treated as data; there is no resynchronisation except by error or timeout.
REQ-028 o_frame_done and o_frame_err SHALL never be high in the same cycle.

Reset
REQ-029 While i_rst=1 at a clock edge:
- FSM goes to IDLE;
- all outputs, shadow registers, index, XOR and timeout counter go to 0.
REQ-030 Reset mid-frame discards the partial frame; the first frame after reset needs a fresh HDR.

Verification
REQ-031 Nominal frame: 21 bytes with byte1=8'hF2 and bytes2-18=8'h37, checksum=8'hF2^(17 x 8'h37)=8'hC5, footer 55 -> 1 cycle after the footer strobe: o_ch_power=F2, every attn/phase field=6'h37, o_frame_done=1 for 1 cycle.
REQ-032 Same frame with checksum byte 8'h00 -> o_frame_err pulse with o_err_code=01; outputs keep their prior values.
REQ-033 Valid checksum followed by footer 8'h54 -> o_frame_err pulse with o_err_code=10; outputs unchanged.
REQ-034 Stop after byte 10 and wait TIMEOUT_CLKS cycles -> o_frame_err with o_err_code=11, o_busy=0; a following valid frame commits correctly.
REQ-035 Garbage bytes 00,FF,13 before HDR, then a valid frame -> garbage ignored and the frame commits.
REQ-036 Assert i_rst after byte 12 -> all outputs 0; the rest of the interrupted frame produces no commit; the next full frame commits.
